// File: rtl/execution_sequencer.sv
// Purpose : Moore FSM pacing each instruction through BOOT, LOAD, DISPATCH, EXEC, ADVANCE (plus JUMP, HALT).
// Latency : outputs decode from the state register; every input acts one clock after it is sampled.
// Backpr. : none; enable=0 freezes state, counters and outputs (the jump detector keeps sampling).
//
// Ports:
//   clock, reset_n                   : clock; synchronous active-low reset
//   enable                           : 1 = advance, 0 = freeze
//   instruction_finish_control_line  : last microcode step of the current instruction
//   halt / resume                    : level halt request; leave HALT when halt=0 and resume=1
//   jump_flag                        : rising edge requests a program-counter load
//   microcode_sequencer_load_n/enable, microcode_rom_read_enable,
//   program_counter_enable/load_n    : control lines to the PC, microcode counter and ROM
//   halted, step_count, fault        : status
//
// Optional feature: define EXEC_SEQUENCER_WATCHDOG_EN to build the EXEC watchdog.
// Without it, fault is tied to 0 and EXEC may last indefinitely.

module execution_sequencer #(
   parameter int BOOT_CYCLES = 1,
   parameter int JUMP_CYCLES = 1,
   parameter int STEP_W      = 5,
   parameter int MAX_STEPS   = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              instruction_finish_control_line,
   input  logic              halt,
   input  logic              resume,
   input  logic              jump_flag,
   output logic              microcode_sequencer_load_n,
   output logic              microcode_sequencer_enable,
   output logic              microcode_rom_read_enable,
   output logic              program_counter_enable,
   output logic              program_counter_load_n,
   output logic              halted,
   output logic [STEP_W-1:0] step_count,
   output logic              fault
);

   // One counter serves both the BOOT delay and the JUMP hold; the two never overlap.
   localparam int CNT_MAX = (BOOT_CYCLES > JUMP_CYCLES) ? BOOT_CYCLES : JUMP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   generate
      if (BOOT_CYCLES < 1 || JUMP_CYCLES < 1 || MAX_STEPS < 1 || MAX_STEPS >= (1 << STEP_W)) begin : g_bad_params
         $error("execution_sequencer: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_BOOT,
      S_LOAD,
      S_DISPATCH,
      S_EXEC,
      S_ADVANCE,
      S_JUMP,
      S_HALT
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [STEP_W-1:0]  step_nxt;
   logic               jump_q;
   logic               jump_edge;
   logic               fault_q;

   // The detector samples even while frozen, so an edge seen during enable=0 is consumed there
   // and cannot fire later when jump_flag is still high.
   assign jump_edge = jump_flag & ~jump_q;

`ifdef EXEC_SEQUENCER_WATCHDOG_EN
   logic fault_nxt;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_nxt;
      end
   end
`else
   assign fault_q = 1'b0;
`endif

   assign fault = fault_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= S_BOOT;
         cnt        <= '0;
         step_count <= '0;
         jump_q     <= 1'b0;
      end else begin
         jump_q     <= jump_flag;
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         step_count <= step_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      step_nxt  = step_count;
`ifdef EXEC_SEQUENCER_WATCHDOG_EN
      fault_nxt = fault_q;
`endif

      if (enable) begin
         // Step counting follows the current state only, independent of halt/jump overrides.
         if (state == S_LOAD) begin
            step_nxt = '0;
         end else if ((state == S_DISPATCH || state == S_EXEC) && step_count != {STEP_W{1'b1}}) begin
            step_nxt = step_count + STEP_W'(1);
         end

         if (halt) begin
            state_nxt = S_HALT;
         end else if (jump_edge && state inside {S_LOAD, S_DISPATCH, S_EXEC, S_ADVANCE, S_JUMP}) begin
            // Entering JUMP, or re-arming the hold when already in JUMP.
            state_nxt = S_JUMP;
            cnt_nxt   = '0;
         end else begin
            case (state)
               S_BOOT: begin
                  if (cnt == CNT_W'(BOOT_CYCLES)) begin
                     state_nxt = S_LOAD;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
               S_LOAD:     state_nxt = S_DISPATCH;
               S_DISPATCH: state_nxt = instruction_finish_control_line ? S_ADVANCE : S_EXEC;
               S_EXEC: begin
`ifdef EXEC_SEQUENCER_WATCHDOG_EN
                  if (!instruction_finish_control_line && step_count == STEP_W'(MAX_STEPS)) begin
                     state_nxt = S_HALT;
                     fault_nxt = 1'b1;
                  end else
`endif
                  if (instruction_finish_control_line) begin
                     state_nxt = S_ADVANCE;
                  end
               end
               S_ADVANCE:  state_nxt = S_LOAD;
               S_JUMP: begin
                  if (cnt == CNT_W'(JUMP_CYCLES - 1)) begin
                     state_nxt = S_LOAD;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
               S_HALT: begin
                  // halt is already known low here; the PC was not advanced, so the
                  // interrupted instruction restarts from its opcode.
                  if (resume && !fault_q) begin
                     state_nxt = S_LOAD;
                  end
               end
               default:    state_nxt = S_BOOT;
            endcase
         end
      end

      microcode_sequencer_load_n = 1'b1;
      microcode_sequencer_enable = 1'b0;
      microcode_rom_read_enable  = 1'b0;
      program_counter_enable     = 1'b0;
      program_counter_load_n     = 1'b1;
      halted                     = 1'b0;

      case (state)
         S_LOAD: begin
            microcode_sequencer_load_n = 1'b0;
            microcode_rom_read_enable  = 1'b1;
         end
         S_DISPATCH: microcode_rom_read_enable = 1'b1;
         S_EXEC: begin
            microcode_rom_read_enable  = 1'b1;
            microcode_sequencer_enable = 1'b1;
         end
         S_ADVANCE:  program_counter_enable = 1'b1;
         S_JUMP:     program_counter_load_n = 1'b0;
         S_HALT:     halted = 1'b1;
         default:    ;
      endcase
   end

endmodule
